sfp_addsub_pipe: RTL and testbench

- Parametrised, pipelined, multi-lane signed fixed-point (sfp) adder/subtractor with valid/ready handshake.
- Each transaction is selected at run time as in1+in2 or in1-in2. Operands are binary-point aligned; the result is resized to a configurable output format.
- Generalises the combinational full-width subtract: adds a lane count, an add/sub mode, narrowed outputs with overflow detection, and backpressure-safe pipelining.
- Sits in the raytracer datapath between vector producers, e.g. ray-origin minus sphere-centre, and multiply stages.

---
 rtl/sfp_pkg.sv | 58 +++++
 rtl/sfp_pipe_reg.sv | 35 +++
 rtl/sfp_addsub_pipe.sv | 127 ++++++++++++
 tb/tb_sfp_addsub_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - shared types and arithmetic helpers for the sfp add/sub pipeline
// Contents:
//   sfp_op_e     - per-transaction operation (SFP_ADD, SFP_SUB)
//   sfp_rs_t     - resize result: overflow flag plus sign-extended value
//   sfp_max      - integer maximum
//   sfp_full_iw  - integer bits needed to hold a sum/difference exactly
//   sfp_resize   - re-format a full-width result to OIW/OQW and detect overflow
package sfp_pkg;

    typedef enum logic {
        SFP_ADD = 1'b0,
        SFP_SUB = 1'b1
    } sfp_op_e;

    // Width of the scratch arithmetic inside sfp_resize; formats must fit below it.
    localparam int SFP_CALC_W = 64;

    typedef struct packed {
        logic                  ovf;
        logic [SFP_CALC_W-1:0] val;
    } sfp_rs_t;

    function automatic int sfp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sfp_full_iw(input int iw1, input int iw2);
        return sfp_max(iw1, iw2) + 1;
    endfunction

    // full: sign-extended value with qa fraction bits.
    // Result val holds the re-formatted value; only its low oiw+oqw bits are meaningful.
    function automatic sfp_rs_t sfp_resize(input logic [SFP_CALC_W-1:0] full,
                                           input int qa, input int oiw,
                                           input int oqw, input logic sat);
        sfp_rs_t                r;
        logic signed [SFP_CALC_W-1:0] v;
        logic signed [SFP_CALC_W-1:0] t;
        int                     wo;
        wo = oiw + oqw;
        // Arithmetic right shift drops fraction LSBs, i.e. rounds toward -inf.
        if (oqw <= qa) begin
            v = $signed(full) >>> (qa - oqw);
        end else begin
            v = $signed(full) <<< (oqw - qa);
        end
        // The value fits when re-extending its low wo bits reproduces it.
        t = (v <<< (SFP_CALC_W - wo)) >>> (SFP_CALC_W - wo);
        r.ovf = (t != v);
        r.val = v;
        if (sat && r.ovf) begin
            r.val = v[SFP_CALC_W-1] ? (64'd1 << (wo - 1))
                                    : ((64'd1 << (wo - 1)) - 64'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sfp_pipe_reg.sv
// rtl/sfp_pipe_reg.sv - one valid/ready register slice
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data captured on transfer
//   out_valid/out_ready downstream handshake, out_data held until transfer
// The slot frees only when the downstream side takes it, so out_data is stable
// while stalled; data is zeroed in reset so outputs read 0.
module sfp_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sfp_addsub_pipe.sv
// rtl/sfp_addsub_pipe.sv - 2-stage multi-lane signed fixed-point adder/subtractor
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_sub selects in1-in2 (1) or in1+in2 (0)
//   in1_val, in2_val      lane k at [k*W1 +: W1] / [k*W2 +: W2]
//   out_valid/out_ready   result handshake
//   out_val, out_ovf      per-lane result (OIW.OQW) and overflow flag
//   ovf_sticky, ovf_clr   accumulated overflow of handed-off results, synchronous clear
// Build option: SFP_ADDSUB_SAT_EN saturates overflowed results instead of wrapping.
module sfp_addsub_pipe
    import sfp_pkg::*;
#(
    parameter int LANES = 3,
    parameter int IW1   = 8,
    parameter int QW1   = 16,
    parameter int IW2   = 8,
    parameter int QW2   = 16,
    parameter int OIW   = 9,
    parameter int OQW   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sub,
    input  logic [LANES*(IW1+QW1)-1:0]   in1_val,
    input  logic [LANES*(IW2+QW2)-1:0]   in2_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*(OIW+OQW)-1:0]   out_val,
    output logic [LANES-1:0]             out_ovf,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int W1 = IW1 + QW1;
    localparam int W2 = IW2 + QW2;
    localparam int WO = OIW + OQW;
    localparam int WA = sfp_full_iw(IW1, IW2);
    localparam int QA = sfp_max(QW1, QW2);
    localparam int WF = WA + QA;

`ifdef SFP_ADDSUB_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    if (LANES < 1 || IW1 < 1 || IW2 < 1 || QW1 < 0 || QW2 < 0 || OIW < 1 || OQW < 0) begin : g_bad_fmt
        $error("sfp_addsub_pipe: illegal lane count or format widths");
    end
    if (OQW > QA) begin : g_bad_oqw
        $error("sfp_addsub_pipe: OQW exceeds the aligned fraction width");
    end
    if (WF >= SFP_CALC_W || WO >= SFP_CALC_W) begin : g_bad_width
        $error("sfp_addsub_pipe: formats too wide for the resize helper");
    end

    sfp_op_e op;
    assign op = sfp_op_e'(in_sub);

    logic [LANES*WF-1:0] s1_d;
    logic [LANES*WF-1:0] s1_q;
    logic                s1_valid;
    logic                s1_ready;
    logic [LANES*WO-1:0] s2_val_d;
    logic [LANES-1:0]    s2_ovf_d;

    // Stage-1 input: align both operands to WA.QA and combine at full width,
    // where every sum/difference (including minus the most-negative in2) is exact.
    for (genvar k = 0; k < LANES; k++) begin : g_s1_lane
        logic [W1-1:0] x1;
        logic [W2-1:0] x2;
        logic [WF-1:0] a_al;
        logic [WF-1:0] b_al;
        assign x1   = in1_val[k*W1 +: W1];
        assign x2   = in2_val[k*W2 +: W2];
        assign a_al = {{(WF-W1){x1[W1-1]}}, x1} << (QA - QW1);
        assign b_al = {{(WF-W2){x2[W2-1]}}, x2} << (QA - QW2);
        assign s1_d[k*WF +: WF] = (op == SFP_SUB) ? (a_al - b_al) : (a_al + b_al);
    end

    sfp_pipe_reg #(.DW(LANES*WF)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_q)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_s2_lane
        logic [WF-1:0] f;
        sfp_rs_t       rs;
        logic          unused_hi;
        assign f  = s1_q[k*WF +: WF];
        assign rs = sfp_resize({{(SFP_CALC_W-WF){f[WF-1]}}, f}, QA, OIW, OQW, SAT);
        assign s2_val_d[k*WO +: WO] = rs.val[WO-1:0];
        assign s2_ovf_d[k]          = rs.ovf;
        assign unused_hi            = ^rs.val[SFP_CALC_W-1:WO];
    end

    sfp_pipe_reg #(.DW(LANES*WO + LANES)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   ({s2_ovf_d, s2_val_d}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_ovf, out_val})
    );

    // A set event in the same cycle as ovf_clr must win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && (|out_ovf)) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfp_addsub_pipe.sv
// tb/tb_sfp_addsub_pipe.sv - directed self-checking bench for sfp_addsub_pipe
module tb_sfp_addsub_pipe;

    localparam int LANES = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic [17:0] in1_val;
    logic [23:0] in2_val;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_val;
    logic [2:0]  out_ovf;
    logic        ovf_sticky;
    logic        ovf_clr;

    int tests;
    int fails;

    // Formats: in1 Q4.2 (6b), in2 Q4.4 (8b), out Q4.2 (6b); full width is Q5.4.
    logic [5:0] a1 [4][3];
    logic [7:0] a2 [4][3];
    logic [5:0] ev [4][3];
    logic [2:0] eo [4];
    logic       sb [4];

    sfp_addsub_pipe #(
        .LANES (LANES),
        .IW1   (4),
        .QW1   (2),
        .IW2   (4),
        .QW2   (4),
        .OIW   (4),
        .OQW   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sub     (in_sub),
        .in1_val    (in1_val),
        .in2_val    (in2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int t, input logic v);
        in_valid = v;
        in_sub   = sb[t];
        in1_val  = {a1[t][2], a1[t][1], a1[t][0]};
        in2_val  = {a2[t][2], a2[t][1], a2[t][0]};
    endtask

    function automatic logic [17:0] expv(input int t);
        return {ev[t][2], ev[t][1], ev[t][0]};
    endfunction

    initial begin
        int  tx;
        int  rx;
        int  last_rx;
        logic acc;
        logic hand;

        tests = 0;
        fails = 0;

        // T0 add: 1.5+0.5=2.0, 0.25+0.1875=0.4375->0.25, 7.75+0 (max, no ovf)
        sb[0] = 1'b0;
        a1[0] = '{6'h06, 6'h01, 6'h1F}; a2[0] = '{8'h08, 8'h03, 8'h00};
        ev[0] = '{6'h08, 6'h01, 6'h1F}; eo[0] = 3'b000;
        // T1 sub: 1.5-0.5=1.0, 0-0.0625 -> floor -0.25, -8-0 (min, no ovf)
        sb[1] = 1'b1;
        a1[1] = '{6'h06, 6'h00, 6'h20}; a2[1] = '{8'h08, 8'h01, 8'h00};
        ev[1] = '{6'h04, 6'h3F, 6'h20}; eo[1] = 3'b000;
        // T2 sub: 7.75-(-8)=15.75 ovf, -8-1=-9 ovf, 1.5-0.5=1.0
        sb[2] = 1'b1;
        a1[2] = '{6'h1F, 6'h20, 6'h06}; a2[2] = '{8'h80, 8'h10, 8'h08};
        // T3 add: -8+-8=-16 ovf, 1.5+0.5=2.0, 0.25+0.1875 -> 0.25
        sb[3] = 1'b0;
        a1[3] = '{6'h20, 6'h06, 6'h01}; a2[3] = '{8'h80, 8'h08, 8'h03};
`ifdef SFP_ADDSUB_SAT_EN
        ev[2] = '{6'h1F, 6'h20, 6'h04};
        ev[3] = '{6'h20, 6'h08, 6'h01};
`else
        ev[2] = '{6'h3F, 6'h1C, 6'h04};
        ev[3] = '{6'h00, 6'h08, 6'h01};
`endif
        eo[2] = 3'b011;
        eo[3] = 3'b001;

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in1_val = '0; in2_val = '0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Latency: accept at edge A, result visible after edge A+1
        drive(0, 1'b1);
        tick();
        check("lat_a_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("lat_b_valid", 32'(out_valid), 32'd1);
        check("t0_val", 32'(out_val), 32'(expv(0)));
        check("t0_ovf", 32'(out_ovf), 32'(eo[0]));
        tick();
        check("t0_gone", 32'(out_valid), 32'd0);

        // Back-to-back T1, T2; sticky sets the cycle after the overflowing handoff
        drive(1, 1'b1);
        tick();
        drive(2, 1'b1);
        tick();
        check("t1_val", 32'(out_val), 32'(expv(1)));
        check("t1_ovf", 32'(out_ovf), 32'(eo[1]));
        in_valid = 1'b0;
        tick();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_val", 32'(out_val), 32'(expv(2)));
        check("t2_ovf", 32'(out_ovf), 32'(eo[2]));
        check("t2_sticky_pre", 32'(ovf_sticky), 32'd0);
        tick();
        check("t2_sticky_set", 32'(ovf_sticky), 32'd1);
        check("t2_gone", 32'(out_valid), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_alone_a", 32'(ovf_sticky), 32'd0);

        // Stalled overflowing result, then handoff coincident with ovf_clr
        out_ready = 1'b0;
        drive(3, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_val", 32'(out_val), 32'(expv(3)));
        check("t3_ovf", 32'(out_ovf), 32'(eo[3]));
        tick();
        check("t3_hold_val", 32'(out_val), 32'(expv(3)));
        check("t3_hold_sticky", 32'(ovf_sticky), 32'd0);
        ovf_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        check("clr_vs_set", 32'(ovf_sticky), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("clr_alone_b", 32'(ovf_sticky), 32'd0);

        // Backpressure: 8 transactions, out_ready low in cycles 3..5
        tx = 0; rx = 0; last_rx = -1;
        for (int c = 0; c < 16; c++) begin
            if (tx < 8) drive(tx % 4, 1'b1);
            else in_valid = 1'b0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'(out_ready));
            if (out_valid) begin
                check("bp_val", 32'(out_val), 32'(expv(rx % 4)));
                check("bp_ovf", 32'(out_ovf), 32'(eo[rx % 4]));
            end
            acc  = in_valid && in_ready;
            hand = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (acc) tx++;
            if (hand) begin
                rx++;
                last_rx = c;
            end
        end
        check("bp_tx_count", 32'(tx), 32'd8);
        check("bp_rx_count", 32'(rx), 32'd8);
        check("bp_last_cycle", 32'(last_rx), 32'd12);
        check("bp_sticky", 32'(ovf_sticky), 32'd1);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(0, 1'b1);
        tick();
        drive(1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        check("mid_pre_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_val", 32'(out_val), 32'd0);
        check("mid_rst_ovf", 32'(out_ovf), 32'd0);
        check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Normal operation after reset
        drive(2, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_val", 32'(out_val), 32'(expv(2)));
        check("post_rst_ovf", 32'(out_ovf), 32'(eo[2]));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
